// File: rtl/demux_lane_collector.sv
// Buffers demux lanes B/C in per-lane FIFOs and re-serialises them round-robin onto one tagged stream.
// Latency: push at edge k is visible at edge k+1; stall holds the output register while FIFOs keep filling (full drops, sticky ovf).
module demux_lane_collector #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_lane,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_c,
  output logic              ovf_b,
  output logic              ovf_c
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_b_q [DEPTH];
  logic [DATA_W-1:0] mem_c_q [DEPTH];

  logic [PTR_W-1:0]  wr_b_q, wr_b_d, rd_b_q, rd_b_d;
  logic [PTR_W-1:0]  wr_c_q, wr_c_d, rd_c_q, rd_c_d;
  logic [CNT_W-1:0]  cnt_b_q, cnt_b_d, cnt_c_q, cnt_c_d;
  logic              ovf_b_q, ovf_b_d, ovf_c_q, ovf_c_d;
  logic              last_c_q, last_c_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_lane_q, out_lane_d;

  logic full_b, full_c, ne_b, ne_c;
  logic req_b, req_c, push_b, push_c;
  logic load, pick_c, pop_b, pop_c;

  always_comb begin
    full_b = (cnt_b_q == FULL_CNT);
    full_c = (cnt_c_q == FULL_CNT);
    ne_b   = (cnt_b_q != '0);
    ne_c   = (cnt_c_q != '0);
    req_b  = in_valid && !in_sel;
    req_c  = in_valid && in_sel;
    push_b = req_b && !full_b;
    push_c = req_c && !full_c;

    // Pop decision uses pre-edge occupancy only, so a same-edge push cannot bypass.
    load   = !out_valid_q || out_ready;
    pick_c = (ne_b && ne_c) ? !last_c_q : ne_c;
    pop_b  = load && ne_b && !pick_c;
    pop_c  = load && ne_c && pick_c;

    wr_b_d  = wr_b_q + PTR_W'(push_b);
    wr_c_d  = wr_c_q + PTR_W'(push_c);
    rd_b_d  = rd_b_q + PTR_W'(pop_b);
    rd_c_d  = rd_c_q + PTR_W'(pop_c);
    cnt_b_d = cnt_b_q + CNT_W'(push_b) - CNT_W'(pop_b);
    cnt_c_d = cnt_c_q + CNT_W'(push_c) - CNT_W'(pop_c);
    ovf_b_d = ovf_b_q || (req_b && full_b);
    ovf_c_d = ovf_c_q || (req_c && full_c);

    last_c_d    = last_c_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    if (load) begin
      if (pop_b) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_b_q[rd_b_q];
        out_lane_d  = 1'b0;
        last_c_d    = 1'b0;
      end else if (pop_c) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_c_q[rd_c_q];
        out_lane_d  = 1'b1;
        last_c_d    = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_b) mem_b_q[wr_b_q] <= in_b;
    if (!rst && push_c) mem_c_q[wr_c_q] <= in_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_b_q      <= '0;
      rd_b_q      <= '0;
      wr_c_q      <= '0;
      rd_c_q      <= '0;
      cnt_b_q     <= '0;
      cnt_c_q     <= '0;
      ovf_b_q     <= 1'b0;
      ovf_c_q     <= 1'b0;
      last_c_q    <= 1'b1;  // "C went last" so B wins the first tie
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= 1'b0;
    end else begin
      wr_b_q      <= wr_b_d;
      rd_b_q      <= rd_b_d;
      wr_c_q      <= wr_c_d;
      rd_c_q      <= rd_c_d;
      cnt_b_q     <= cnt_b_d;
      cnt_c_q     <= cnt_c_d;
      ovf_b_q     <= ovf_b_d;
      ovf_c_q     <= ovf_c_d;
      last_c_q    <= last_c_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign cnt_b     = cnt_b_q;
  assign cnt_c     = cnt_c_q;
  assign ovf_b     = ovf_b_q;
  assign ovf_c     = ovf_c_q;

endmodule

// File: tb/tb_demux_lane_collector.sv
// Bench for demux_lane_collector: queue-based reference model feeds a scoreboard; a negedge monitor checks accepted words and stall stability.
module tb_demux_lane_collector;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_sel = 1'b0;
  logic [DATA_W-1:0] in_b = '0;
  logic [DATA_W-1:0] in_c = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_lane;
  logic [CNT_W-1:0]  cnt_b, cnt_c;
  logic              ovf_b, ovf_c;

  demux_lane_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .cnt_b(cnt_b), .cnt_c(cnt_c), .ovf_b(ovf_b), .ovf_c(ovf_c)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: per-lane contents as queues, plus the output slot and whoever won last.
  int mb[$];
  int mc[$];
  bit m_valid = 1'b0;
  bit m_last_c = 1'b1;
  bit m_ovf_b = 1'b0;
  bit m_ovf_c = 1'b0;
  int exp_q[$];   // expected accepted words, encoded lane*4 + data
  int acc_q[$];   // words actually accepted, same encoding

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit sel, input int b, input int c, input bit rdy);
    int nb, nc;
    if (r) begin
      mb.delete(); mc.delete(); exp_q.delete();
      m_valid = 1'b0; m_last_c = 1'b1; m_ovf_b = 1'b0; m_ovf_c = 1'b0;
      return;
    end
    nb = mb.size();
    nc = mc.size();
    if (!m_valid || rdy) begin
      if (nb > 0 && (nc == 0 || m_last_c)) begin
        exp_q.push_back(mb.pop_front());
        m_valid = 1'b1; m_last_c = 1'b0;
      end else if (nc > 0) begin
        exp_q.push_back(4 + mc.pop_front());
        m_valid = 1'b1; m_last_c = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (v && !sel) begin
      if (nb == DEPTH) m_ovf_b = 1'b1; else mb.push_back(b);
    end
    if (v && sel) begin
      if (nc == DEPTH) m_ovf_c = 1'b1; else mc.push_back(c);
    end
  endtask

  // One clock: drive, advance model, then compare state-type outputs 1ns after the edge.
  task automatic step(input bit r, input bit v, input bit sel, input int b, input int c, input bit rdy);
    rst = r; in_valid = v; in_sel = sel;
    in_b = DATA_W'(b); in_c = DATA_W'(c); out_ready = rdy;
    model_edge(r, v, sel, b, c, rdy);
    @(posedge clk);
    #1;
    chk("cnt_b", int'(cnt_b), mb.size());
    chk("cnt_c", int'(cnt_c), mc.size());
    chk("ovf_b", int'(ovf_b), int'(m_ovf_b));
    chk("ovf_c", int'(ovf_c), int'(m_ovf_c));
    chk("out_valid", int'(out_valid), int'(m_valid));
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, rdy);
  endtask

  task automatic check_acc(input string name, input int e[$]);
    chk({name, " count"}, acc_q.size(), e.size());
    for (int i = 0; i < e.size() && i < acc_q.size(); i++) chk(name, acc_q[i], e[i]);
  endtask

  // Monitor: inputs settle 2ns after posedge, so negedge sees the handshake of the coming edge.
  bit hold_pend = 1'b0;
  int hold_word = 0;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("stall valid", int'(out_valid), 1);
        chk("stall word", int'({out_lane, out_data}), hold_word);
      end
      if (out_valid && out_ready) begin
        acc_q.push_back(int'({out_lane, out_data}));
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb word: got %0d expected nothing (scoreboard empty)", int'({out_lane, out_data}));
        end else begin
          chk("sb word", int'({out_lane, out_data}), exp_q.pop_front());
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_word = int'({out_lane, out_data});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[$];
    // Reset for two cycles, then idle.
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst out_lane", int'(out_lane), 0);
    idle(5, 1'b0);

    // Single B then single C with ready high.
    acc_q.delete();
    step(1'b0, 1'b1, 1'b0, 1, 0, 1'b1);
    chk("lat valid early", int'(out_valid), 0);
    step(1'b0, 1'b1, 1'b1, 0, 2, 1'b1);
    chk("lat valid", int'(out_valid), 1);
    chk("lat data", int'(out_data), 1);
    idle(3, 1'b1);
    e = {1, 6};
    check_acc("pair", e);
    chk("pair cnt_b", int'(cnt_b), 0);
    chk("pair cnt_c", int'(cnt_c), 0);

    // Fill under stall, then release: round-robin interleave.
    acc_q.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, i, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 0, 3 - i, 1'b0);
    idle(10, 1'b1);
    e = {0, 7, 1, 6, 2, 5, 3, 4};
    check_acc("rr order", e);

    // Overflow: a C word first occupies the output register, so B's FIFO alone takes the next four.
    acc_q.delete();
    step(1'b0, 1'b1, 1'b1, 0, 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, i % 4, 0, 1'b0);
      if (i == 3) begin
        chk("ovf cnt_b full", int'(cnt_b), 4);
        chk("ovf not yet", int'(ovf_b), 0);
      end
      if (i == 4) chk("ovf set", int'(ovf_b), 1);
    end
    idle(10, 1'b1);
    e = {6, 0, 1, 2, 3};
    check_acc("ovf drain", e);
    chk("ovf sticky", int'(ovf_b), 1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    idle(12, 1'b1);
    chk("no loss", exp_q.size(), 0);
    chk("rand ovf sticky", int'(ovf_b), 1);

    // Reset in the middle of a full, stalled stream.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'(i % 2), i % 4, (i + 1) % 4, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1, 1, 1'b1);
    chk("mid rst cnt_b", int'(cnt_b), 0);
    chk("mid rst cnt_c", int'(cnt_c), 0);
    chk("mid rst valid", int'(out_valid), 0);
    chk("mid rst ovf_b", int'(ovf_b), 0);
    chk("mid rst ovf_c", int'(ovf_c), 0);
    step(1'b0, 1'b1, 1'b0, 3, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    chk("post rst valid", int'(out_valid), 1);
    chk("post rst data", int'(out_data), 3);
    chk("post rst lane", int'(out_lane), 0);
    idle(4, 1'b1);
    chk("final empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
